bht_ctrl_128: RTL and testbench

Controller for the 128-entry table of 2-bit saturating branch counters that the fetch stage reads through the 128:1 2-bit read mux. It owns the counter storage and the read selection, and applies resolved-branch updates from execute. It also runs a sequenced clear sweep on request, used by pipeline flush and context reset. Fetch gets a combinational taken/not-taken prediction each cycle.

---
 rtl/bht_ctrl_128_pkg.sv | 22 ++
 rtl/bht_ctrl_128_sat_counter_2b.sv | 19 +
 rtl/bht_ctrl_128.sv | 111 +++++++++++
 tb/tb_bht_ctrl_128.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bht_ctrl_128_pkg.sv
// Shared definitions for the 128-entry branch history table controller:
// counter encodings, FSM states and table geometry.
package bht_ctrl_128_pkg;

    localparam int ENTRIES = 128;
    localparam int IDX_W   = 7;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [1:0] INIT_STATE = WNT;

    typedef enum logic {
        FSM_IDLE  = 1'b0,
        FSM_CLEAR = 1'b1
    } fsm_e;

endpackage

// File: rtl/bht_ctrl_128_sat_counter_2b.sv
// Two-bit saturating counter next-state function used on the update path.
module sat_counter_2b
    import bht_ctrl_128_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = state;
        if (taken) begin
            if (state != ST) next = state + 2'd1;
        end else begin
            if (state != SNT) next = state - 2'd1;
        end
    end

endmodule

// File: rtl/bht_ctrl_128.sv
// Branch history table controller: owns 128 two-bit counters, serves the
// fetch-stage lookup combinationally and applies execute-stage updates.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FSM_IDLE  | normal operation; updates accepted, lookups show the table
// FSM_CLEAR | sweeping entry[ptr] back to INIT_STATE, one entry per cycle
module bht_ctrl_128
    import bht_ctrl_128_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] lookup_index,
    output logic [1:0]       pred_state,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken,
    input  logic             clear_req,
    output logic             busy,
    output logic [15:0]      upd_count
);

    logic [1:0]       entry_q [ENTRIES];
    fsm_e             state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [15:0]      upd_count_q, upd_count_d;

    logic             upd_we;
    logic             clr_we;
    logic [1:0]       upd_cur;
    logic [1:0]       upd_next;
    logic [1:0]       lo_state;
    logic [1:0]       hi_state;
    logic [1:0]       raw_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= FSM_IDLE;
            ptr_q       <= '0;
            upd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            upd_count_q <= upd_count_d;
        end
    end

    // A clear request in IDLE takes priority over a same-cycle update.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        upd_count_d = upd_count_q;
        upd_we      = 1'b0;
        clr_we      = 1'b0;
        case (state_q)
            FSM_IDLE: begin
                if (clear_req) begin
                    state_d = FSM_CLEAR;
                    ptr_d   = '0;
                end else if (upd_valid) begin
                    upd_we      = 1'b1;
                    upd_count_d = upd_count_q + 16'd1;
                end
            end
            FSM_CLEAR: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = FSM_IDLE;
                end
            end
            default: begin
                state_d = FSM_IDLE;
            end
        endcase
    end

    assign upd_cur = entry_q[upd_index];

    sat_counter_2b u_sat (
        .state (upd_cur),
        .taken (upd_taken),
        .next  (upd_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) entry_q[i] <= INIT_STATE;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (clr_we && (ptr_q == IDX_W'(i))) begin
                    entry_q[i] <= INIT_STATE;
                end else if (upd_we && (upd_index == IDX_W'(i))) begin
                    entry_q[i] <= upd_next;
                end
            end
        end
    end

    // 128:1 read mux split on bit 6 into two 64-entry halves.
    assign lo_state  = entry_q[{1'b0, lookup_index[IDX_W-2:0]}];
    assign hi_state  = entry_q[{1'b1, lookup_index[IDX_W-2:0]}];
    assign raw_state = lookup_index[IDX_W-1] ? hi_state : lo_state;

    assign busy       = (state_q == FSM_CLEAR);
    assign pred_state = busy ? INIT_STATE : raw_state;
    assign pred_taken = pred_state[1];
    assign upd_count  = upd_count_q;

endmodule

// File: tb/tb_bht_ctrl_128.sv
// Scoreboard bench for bht_ctrl_128: expected outputs are queued by the
// stimulus from a table-level model and checked by a separate monitor.
module tb_bht_ctrl_128;

    logic        clock;
    logic        reset;
    logic [6:0]  lookup_index;
    logic [1:0]  pred_state;
    logic        pred_taken;
    logic        upd_valid;
    logic [6:0]  upd_index;
    logic        upd_taken;
    logic        clear_req;
    logic        busy;
    logic [15:0] upd_count;

    bht_ctrl_128 dut (
        .clock        (clock),
        .reset        (reset),
        .lookup_index (lookup_index),
        .pred_state   (pred_state),
        .pred_taken   (pred_taken),
        .upd_valid    (upd_valid),
        .upd_index    (upd_index),
        .upd_taken    (upd_taken),
        .clear_req    (clear_req),
        .busy         (busy),
        .upd_count    (upd_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         id;
        logic [1:0] ps;
        logic       pt;
        logic       b;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   seq   = 0;

    // table-level reference model
    int m_tbl [128];
    int m_sweep_left;
    int m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 128; i++) m_tbl[i] = 1;
        m_sweep_left = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_step(input bit uv, input int ui, input bit ut, input bit cr);
        if (m_sweep_left > 0) begin
            m_sweep_left = m_sweep_left - 1;
        end else if (cr) begin
            m_sweep_left = 128;
            for (int i = 0; i < 128; i++) m_tbl[i] = 1;
        end else if (uv) begin
            if (ut) m_tbl[ui] = (m_tbl[ui] >= 3) ? 3 : m_tbl[ui] + 1;
            else    m_tbl[ui] = (m_tbl[ui] <= 0) ? 0 : m_tbl[ui] - 1;
            m_cnt = (m_cnt + 1) % 65536;
        end
    endfunction

    function automatic void push_exp(input int li);
        exp_t e;
        int v;
        v = (m_sweep_left > 0) ? 1 : m_tbl[li];
        e.id  = seq;
        e.ps  = 2'(v);
        e.pt  = (v >= 2);
        e.b   = (m_sweep_left > 0);
        e.cnt = 16'(m_cnt);
        exp_q.push_back(e);
        seq++;
    endfunction

    task automatic drive(input int li, input bit uv, input int ui, input bit ut, input bit cr);
        lookup_index = 7'(li);
        upd_valid    = uv;
        upd_index    = 7'(ui);
        upd_taken    = ut;
        clear_req    = cr;
        push_exp(li);
        @(posedge clock);
        model_step(uv, ui, ut, cr);
        #1;
    endtask

    task automatic look(input int li);
        drive(li, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // monitor: the DUT presents its outputs every cycle; compare mid-cycle
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (pred_state !== e.ps) begin
                bad++;
                $display("FAIL pred_state #%0d: got %b want %b", e.id, pred_state, e.ps);
            end
            total++;
            if (pred_taken !== e.pt) begin
                bad++;
                $display("FAIL pred_taken #%0d: got %b want %b", e.id, pred_taken, e.pt);
            end
            total++;
            if (busy !== e.b) begin
                bad++;
                $display("FAIL busy #%0d: got %b want %b", e.id, busy, e.b);
            end
            total++;
            if (upd_count !== e.cnt) begin
                bad++;
                $display("FAIL upd_count #%0d: got %0d want %0d", e.id, upd_count, e.cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int li, ui;
        bit uv, ut, cr;

        reset = 1'b1;
        lookup_index = '0;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_taken = 1'b0;
        clear_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // reset state at the half boundaries
        look(0); look(63); look(64); look(127);

        // taken saturation on an upper-half entry; entry 6 shares low bits
        for (int k = 0; k < 4; k++) drive(70, 1'b1, 70, 1'b1, 1'b0);
        look(70);
        look(6);

        // not-taken saturation, then read-before-write on the same index
        drive(5, 1'b1, 5, 1'b0, 1'b0);
        drive(5, 1'b1, 5, 1'b0, 1'b0);
        drive(5, 1'b1, 5, 1'b1, 1'b0);
        look(5);

        // load some strong-taken entries, then sweep with updates in flight
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 0, 1'b1, 1'b0);
            drive(64, 1'b1, 64, 1'b1, 1'b0);
            drive(127, 1'b1, 127, 1'b1, 1'b0);
        end
        look(127);
        drive(0, 1'b0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 128; k++) begin
            li = (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 64 : 127);
            drive(li, 1'b1, li, 1'b1, (k % 17 == 0));
        end
        for (int i = 0; i < 128; i++) look(i);

        // clear wins over a same-cycle update
        drive(9, 1'b1, 9, 1'b1, 1'b1);
        for (int k = 0; k < 128; k++) look(9);
        look(9);
        look(9);

        // reset in the middle of a sweep
        drive(70, 1'b1, 70, 1'b1, 1'b0);
        drive(70, 1'b0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) drive(70, 1'b1, 3, 1'b1, 1'b0);
        reset = 1'b1;
        model_reset();
        lookup_index = 7'd70;
        upd_valid = 1'b0;
        clear_req = 1'b0;
        #1;
        push_exp(70);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(3, 1'b1, 3, 1'b1, 1'b0);
        look(3);
        for (int i = 0; i < 128; i += 9) look(i);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            uv = ($urandom_range(0, 9) < 7);
            ui = $urandom_range(0, 127);
            ut = $urandom_range(0, 1);
            cr = ($urandom_range(0, 149) == 0);
            li = ($urandom_range(0, 3) == 0) ? ui : $urandom_range(0, 127);
            drive(li, uv, ui, ut, cr);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
